// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: bus widths,
// transmitter state encoding and the router header packing rule.
package router_pkg;

    localparam int ROUTER_ADDR_W = 2;
    localparam int ROUTER_LEN_W  = 6;
    localparam int ROUTER_DATA_W = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_HDR,
        TX_PLD,
        TX_PAR,
        TX_GAP
    } tx_state_t;

    // Router header byte: payload length in the upper bits, destination port in the lower bits.
    function automatic logic [ROUTER_DATA_W-1:0] router_hdr(
        input logic [ROUTER_LEN_W-1:0]  len,
        input logic [ROUTER_ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload byte buffer: one synchronous write port, one asynchronous read port.
// Holds one packet's payload between the load phase and transmission.
module router_tx_buf
    import router_pkg::*;
(
    input  logic                     clock,
    input  logic                     we,
    input  logic [ROUTER_LEN_W-1:0]  wr_addr,
    input  logic [ROUTER_DATA_W-1:0] wr_data,
    input  logic [ROUTER_LEN_W-1:0]  rd_addr,
    output logic [ROUTER_DATA_W-1:0] rd_data
);

    logic [ROUTER_DATA_W-1:0] mem [2**ROUTER_LEN_W];

    // Byte write during the load phase.
    // NOTE: the storage array has no reset; every byte is written before it is read.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter. Accepts a (destination, length) request,
// buffers the payload, then sends header, payload and parity to the router,
// holding the current byte whenever the router asserts busy.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [ROUTER_ADDR_W-1:0] dest_addr,
    input  logic [ROUTER_LEN_W-1:0]  pay_len,
    input  logic [ROUTER_DATA_W-1:0] pay_data,
    input  logic                     pay_valid,
    output logic                     pay_ready,
    input  logic                     busy,
    output logic [ROUTER_DATA_W-1:0] data_out,
    output logic                     pkt_valid,
    output logic                     tx_ready,
    output logic                     tx_done,
    output logic                     req_err
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    tx_state_t                state, state_next;
    logic [ROUTER_LEN_W-1:0]  len_q, len_next;
    logic [ROUTER_ADDR_W-1:0] dest_q, dest_next;
    logic [ROUTER_LEN_W-1:0]  idx, idx_next;
    logic [ROUTER_DATA_W-1:0] parity, parity_next;
    logic [3:0]               gap_cnt, gap_next;
    logic [ROUTER_DATA_W-1:0] data_next;
    logic                     valid_next;
    logic                     done_next;
    logic                     err_next;

    logic                     buf_we;
    logic [ROUTER_LEN_W-1:0]  rd_addr;
    logic [ROUTER_DATA_W-1:0] rd_data;
    logic                     idx_last;
    logic                     req_legal;

    assign idx_last  = (idx == len_q - ROUTER_LEN_W'(1));
    assign req_legal = (dest_addr != 2'd3) && (pay_len != '0);

    // In HDR the next byte out is buf[0]; in PLD it is the one after the current index.
    assign rd_addr = (state == TX_PLD) ? idx + ROUTER_LEN_W'(1) : '0;

    assign tx_ready  = (state == TX_IDLE);
    assign pay_ready = (state == TX_LOAD);

    router_tx_buf u_buf (
        .clock   (clock),
        .we      (buf_we),
        .wr_addr (idx),
        .wr_data (pay_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state and next-register decode; busy only matters while a byte is on the bus.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_next  = state;
        len_next    = len_q;
        dest_next   = dest_q;
        idx_next    = idx;
        parity_next = parity;
        gap_next    = gap_cnt;
        data_next   = data_out;
        valid_next  = pkt_valid;
        done_next   = 1'b0;
        err_next    = 1'b0;
        buf_we      = 1'b0;

        unique case (state)
            TX_IDLE: begin
                if (start) begin
                    if (req_legal) begin
                        len_next    = pay_len;
                        dest_next   = dest_addr;
                        idx_next    = '0;
                        parity_next = router_hdr(pay_len, dest_addr);
                        state_next  = TX_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            TX_LOAD: begin
                if (pay_valid) begin
                    buf_we      = 1'b1;
                    parity_next = parity ^ pay_data;
                    if (idx_last) begin
                        idx_next   = '0;
                        data_next  = router_hdr(len_q, dest_q);
                        valid_next = 1'b1;
                        state_next = TX_HDR;
                    end else begin
                        idx_next = idx + ROUTER_LEN_W'(1);
                    end
                end
            end
            TX_HDR: begin
                if (!busy) begin
                    data_next  = rd_data;
                    state_next = TX_PLD;
                end
            end
            TX_PLD: begin
                if (!busy) begin
                    if (idx_last) begin
                        data_next  = parity;
                        valid_next = 1'b0;
                        state_next = TX_PAR;
                    end else begin
                        idx_next  = idx + ROUTER_LEN_W'(1);
                        data_next = rd_data;
                    end
                end
            end
            TX_PAR: begin
                if (!busy) begin
                    done_next  = 1'b1;
                    data_next  = '0;
                    gap_next   = '0;
                    state_next = TX_GAP;
                end
            end
            TX_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = TX_IDLE;
                end else begin
                    gap_next = gap_cnt + 4'd1;
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_q     <= '0;
            dest_q    <= '0;
            idx       <= '0;
            parity    <= '0;
            gap_cnt   <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            tx_done   <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            len_q     <= len_next;
            dest_q    <= dest_next;
            idx       <= idx_next;
            parity    <= parity_next;
            gap_cnt   <= gap_next;
            data_out  <= data_next;
            pkt_valid <= valid_next;
            tx_done   <= done_next;
            req_err   <= err_next;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx. Two instances share all inputs: u_dut uses
// the default gap of 2, u_dut_g1 a gap of 1; sel chooses which one is observed.
module tb_router_pkt_tx;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       busy;

    logic [7:0] data_out0, data_out1;
    logic       pkt_valid0, pkt_valid1;
    logic       pay_ready0, pay_ready1;
    logic       tx_ready0, tx_ready1;
    logic       tx_done0, tx_done1;
    logic       req_err0, req_err1;

    logic       sel;
    int         exp_gap;
    logic [7:0] data_out_m;
    logic       pkt_valid_m, pay_ready_m, tx_ready_m, tx_done_m, req_err_m;

    logic [7:0] pay_bytes [64];
    int         n_checks;
    int         n_errors;

    assign data_out_m  = sel ? data_out1  : data_out0;
    assign pkt_valid_m = sel ? pkt_valid1 : pkt_valid0;
    assign pay_ready_m = sel ? pay_ready1 : pay_ready0;
    assign tx_ready_m  = sel ? tx_ready1  : tx_ready0;
    assign tx_done_m   = sel ? tx_done1   : tx_done0;
    assign req_err_m   = sel ? req_err1   : req_err0;

    router_pkt_tx u_dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .dest_addr (dest_addr),
        .pay_len   (pay_len),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready0),
        .busy      (busy),
        .data_out  (data_out0),
        .pkt_valid (pkt_valid0),
        .tx_ready  (tx_ready0),
        .tx_done   (tx_done0),
        .req_err   (req_err0)
    );

    router_pkt_tx #(.GAP_CYCLES(1)) u_dut_g1 (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .dest_addr (dest_addr),
        .pay_len   (pay_len),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready1),
        .busy      (busy),
        .data_out  (data_out1),
        .pkt_valid (pkt_valid1),
        .tx_ready  (tx_ready1),
        .tx_done   (tx_done1),
        .req_err   (req_err1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Request, load and transmit one packet; bit c of busy_mask is busy in transmit cycle c.
    // Returns early, with byte abort_at on the bus, when abort_at >= 0.
    task automatic run_pkt(input logic [1:0] dest, input logic [5:0] len,
                           input logic [7:0] hdr, input logic [7:0] par,
                           input logic [63:0] busy_mask, input logic load_busy,
                           input int abort_at);
        int         n;
        int         g;
        logic [7:0] exp_b;
        logic       exp_v;
        logic [7:0] prev_d;
        logic       prev_v;
        logic       prev_busy;

        check("idle_tx_ready", 32'(tx_ready_m), 32'd1);
        start     = 1'b1;
        dest_addr = dest;
        pay_len   = len;
        step();
        start = 1'b0;
        check("load_pay_ready", 32'(pay_ready_m), 32'd1);
        check("load_tx_ready", 32'(tx_ready_m), 32'd0);

        busy = load_busy;
        for (int i = 0; i < int'(len); i++) begin
            pay_valid = 1'b1;
            pay_data  = pay_bytes[i];
            step();
            check("load_no_valid", 32'(pkt_valid_m), (i == int'(len) - 1) ? 32'd1 : 32'd0);
        end
        pay_valid = 1'b0;
        pay_data  = 8'h00;
        check("hdr_on_bus", 32'(data_out_m), 32'(hdr));

        n         = 0;
        prev_d    = 8'h00;
        prev_v    = 1'b0;
        prev_busy = 1'b0;
        for (int c = 0; c < 400 && n < int'(len) + 2; c++) begin
            if (n == abort_at) return;
            busy = (c < 64) ? busy_mask[c] : 1'b0;
            if (prev_busy) begin
                check("hold_data", 32'(data_out_m), 32'(prev_d));
                check("hold_valid", 32'(pkt_valid_m), 32'(prev_v));
            end
            if (!busy) begin
                if (n == 0)              exp_b = hdr;
                else if (n <= int'(len)) exp_b = pay_bytes[n-1];
                else                     exp_b = par;
                exp_v = (n <= int'(len));
                check($sformatf("byte%0d", n), 32'(data_out_m), 32'(exp_b));
                check($sformatf("valid%0d", n), 32'(pkt_valid_m), 32'(exp_v));
                n++;
            end
            prev_d    = data_out_m;
            prev_v    = pkt_valid_m;
            prev_busy = busy;
            step();
        end
        busy = 1'b0;
        check("bytes_sent", 32'(n), 32'(int'(len) + 2));
        check("tx_done_pulse", 32'(tx_done_m), 32'd1);
        check("gap_data", 32'(data_out_m), 32'd0);
        check("gap_valid", 32'(pkt_valid_m), 32'd0);

        g = 0;
        while (g < 40 && tx_ready_m !== 1'b1) begin
            step();
            g++;
            check("gap_no_done", 32'(tx_done_m), 32'd0);
            check("gap_idle_valid", 32'(pkt_valid_m), 32'd0);
            check("gap_idle_data", 32'(data_out_m), 32'd0);
        end
        check("gap_len", 32'(g), 32'(exp_gap));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        sel       = 1'b0;
        exp_gap   = 2;
        resetn    = 1'b0;
        start     = 1'b0;
        dest_addr = 2'd0;
        pay_len   = 6'd0;
        pay_data  = 8'h00;
        pay_valid = 1'b0;
        busy      = 1'b0;

        // Reset state.
        #3;
        check("rst_data", 32'(data_out_m), 32'd0);
        check("rst_valid", 32'(pkt_valid_m), 32'd0);
        check("rst_pay_ready", 32'(pay_ready_m), 32'd0);
        check("rst_tx_ready", 32'(tx_ready_m), 32'd1);
        check("rst_tx_done", 32'(tx_done_m), 32'd0);
        check("rst_req_err", 32'(req_err_m), 32'd0);
        #9;
        resetn = 1'b1;
        step();

        // Addr 1, len 3: header 0D, parity 0D.
        pay_bytes[0] = 8'h11;
        pay_bytes[1] = 8'h22;
        pay_bytes[2] = 8'h33;
        run_pkt(2'd1, 6'd3, 8'h0D, 8'h0D, 64'h0, 1'b0, -1);

        // Addr 2, len 2, busy on header (3 cycles) and first payload byte; busy also high during load.
        pay_bytes[0] = 8'hAA;
        pay_bytes[1] = 8'h55;
        run_pkt(2'd2, 6'd2, 8'h0A, 8'hF5, 64'h17, 1'b1, -1);

        // Illegal requests: zero length, then destination 3.
        start     = 1'b1;
        dest_addr = 2'd1;
        pay_len   = 6'd0;
        step();
        start = 1'b0;
        check("err_len0", 32'(req_err_m), 32'd1);
        check("err_len0_idle", 32'(tx_ready_m), 32'd1);
        check("err_len0_valid", 32'(pkt_valid_m), 32'd0);
        step();
        check("err_len0_pulse", 32'(req_err_m), 32'd0);
        start     = 1'b1;
        dest_addr = 2'd3;
        pay_len   = 6'd5;
        step();
        start = 1'b0;
        check("err_dest3", 32'(req_err_m), 32'd1);
        check("err_dest3_idle", 32'(tx_ready_m), 32'd1);
        check("err_dest3_load", 32'(pay_ready_m), 32'd0);
        step();
        check("err_dest3_pulse", 32'(req_err_m), 32'd0);
        check("err_dest3_valid", 32'(pkt_valid_m), 32'd0);

        // Maximum length: bytes 00..3E, header FC, parity FC ^ 3F = C3.
        for (int i = 0; i < 63; i++) pay_bytes[i] = 8'(i);
        run_pkt(2'd0, 6'd63, 8'hFC, 8'hC3, 64'h0, 1'b0, -1);

        // Reset while payload byte 5 is on the bus.
        for (int i = 0; i < 8; i++) pay_bytes[i] = 8'h10 + 8'(i);
        run_pkt(2'd0, 6'd8, 8'h20, 8'h00, 64'h0, 1'b0, 6);
        check("abort_byte5", 32'(data_out_m), 32'h15);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_valid", 32'(pkt_valid_m), 32'd0);
        check("abort_data", 32'(data_out_m), 32'd0);
        check("abort_tx_ready", 32'(tx_ready_m), 32'd1);
        step();
        resetn = 1'b1;
        step();
        check("abort_still_idle", 32'(tx_ready_m), 32'd1);
        pay_bytes[0] = 8'h5A;
        run_pkt(2'd2, 6'd1, 8'h06, 8'h5C, 64'h0, 1'b0, -1);

        // Back-to-back packets on the GAP_CYCLES=1 instance.
        resetn = 1'b0;
        step();
        resetn  = 1'b1;
        sel     = 1'b1;
        exp_gap = 1;
        step();
        pay_bytes[0] = 8'h01;
        pay_bytes[1] = 8'h02;
        run_pkt(2'd0, 6'd2, 8'h08, 8'h0B, 64'h0, 1'b0, -1);
        pay_bytes[0] = 8'hFF;
        run_pkt(2'd1, 6'd1, 8'h05, 8'hFA, 64'h0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
